// File: rtl/branch_queue_if.sv
// ----------------------------------------------------------------------------
// branch_queue_if
//   Bundles every branch_queue signal except clock and reset.
//   master : the environment side (decode, branch unit, commit, flush source)
//   slave  : the branch queue itself
//   Groups:
//     push_*   decode allocates a control-flow uop; push_bqid_o is the slot it gets
//     res_*    branch unit reports the actual outcome of a slot
//     commit   retire the head slot
//     flush    global flush, empties the queue
//     squash_* one-cycle misprediction redirect toward the front end
//     empty_o  queue holds no in-flight branches
// ----------------------------------------------------------------------------
interface branch_queue_if #(
    parameter int NR_ENTRIES = 8,
    parameter int ID_W       = 8,
    parameter int PC_W       = 64,
    parameter int BQID_W     = $clog2(NR_ENTRIES)
);
    logic              push_valid_i;
    logic              push_ready_o;
    logic [PC_W-1:0]   push_pc_i;
    logic [ID_W-1:0]   push_id_i;
    logic              push_bp_taken_i;
    logic [PC_W-1:0]   push_bp_pcnext_i;
    logic [BQID_W-1:0] push_bqid_o;

    logic              res_valid_i;
    logic [BQID_W-1:0] res_bqid_i;
    logic              res_taken_i;
    logic [PC_W-1:0]   res_target_i;

    logic              commit_valid_i;
    logic              flush_i;

    logic              squash_valid_o;
    logic [ID_W-1:0]   squash_id_o;
    logic [PC_W-1:0]   squash_pc_o;
    logic              empty_o;

    modport master (
        output push_valid_i, push_pc_i, push_id_i, push_bp_taken_i, push_bp_pcnext_i,
        output res_valid_i, res_bqid_i, res_taken_i, res_target_i,
        output commit_valid_i, flush_i,
        input  push_ready_o, push_bqid_o,
        input  squash_valid_o, squash_id_o, squash_pc_o, empty_o
    );

    modport slave (
        input  push_valid_i, push_pc_i, push_id_i, push_bp_taken_i, push_bp_pcnext_i,
        input  res_valid_i, res_bqid_i, res_taken_i, res_target_i,
        input  commit_valid_i, flush_i,
        output push_ready_o, push_bqid_o,
        output squash_valid_o, squash_id_o, squash_pc_o, empty_o
    );
endinterface

// File: rtl/branch_queue.sv
// ----------------------------------------------------------------------------
// branch_queue
//   Circular queue of in-flight control-flow uops, from decode allocation to
//   commit. Compares branch-unit outcomes against the recorded prediction and,
//   on a misprediction, truncates every younger entry and emits a one-cycle
//   squash (branch id + redirect PC) on the following cycle.
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset
//     bq    branch_queue_if.slave (push / resolve / commit / flush / squash)
// ----------------------------------------------------------------------------
module branch_queue #(
    parameter int NR_ENTRIES = 8,
    parameter int ID_W       = 8,
    parameter int PC_W       = 64,
    parameter int BQID_W     = $clog2(NR_ENTRIES)
) (
    input  logic           clk,
    input  logic           rstn,
    branch_queue_if.slave  bq
);
    typedef logic [ID_W-1:0] id_t;
    typedef logic [PC_W-1:0] pc_t;

    localparam int PTR_W = BQID_W + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [BQID_W-1:0] head_idx, tail_idx;
    logic              full, empty;

    logic [NR_ENTRIES-1:0] valid_vec;
    logic [NR_ENTRIES-1:0] resolved_vec;
    pc_t                   pc_vec        [NR_ENTRIES];
    id_t                   id_vec        [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] bp_taken_vec;
    pc_t                   bp_pcnext_vec [NR_ENTRIES];

    logic squash_valid_reg;
    id_t  squash_id_reg;
    pc_t  squash_pc_reg;

    logic              res_ok, mispredict, mis_fire;
    logic              push_fire, commit_fire;
    logic [BQID_W-1:0] res_dist;
    logic [PTR_W-1:0]  branch_ptr;
    pc_t               redirect_pc;

    assign head_idx = head_reg[BQID_W-1:0];
    assign tail_idx = tail_reg[BQID_W-1:0];
    assign empty    = (head_reg == tail_reg);
    assign full     = (head_idx == tail_idx) && (head_reg[BQID_W] != tail_reg[BQID_W]);

    assign bq.push_ready_o   = ~full;
    assign bq.push_bqid_o    = tail_idx;
    assign bq.empty_o        = empty;
    assign bq.squash_valid_o = squash_valid_reg;
    assign bq.squash_id_o    = squash_id_reg;
    assign bq.squash_pc_o    = squash_pc_reg;

    // A resolve only counts against a live entry that has not been resolved yet;
    // this also filters stale resolves for entries already truncated.
    assign res_ok = bq.res_valid_i && valid_vec[bq.res_bqid_i] && !resolved_vec[bq.res_bqid_i];

    assign mispredict = (bq.res_taken_i != bp_taken_vec[bq.res_bqid_i]) ||
                        (bq.res_taken_i && (bq.res_target_i != bp_pcnext_vec[bq.res_bqid_i]));

    assign redirect_pc = bq.res_taken_i ? bq.res_target_i : (pc_vec[bq.res_bqid_i] + pc_t'(4));

    // Flush outranks everything, including cancelling the squash it would raise.
    assign mis_fire    = res_ok && mispredict && !bq.flush_i;
    assign commit_fire = bq.commit_valid_i && !empty && !bq.flush_i;
    // Pushes are younger than any branch mispredicting now, and decode is being
    // squashed while the pulse is out, so both cases drop the push.
    assign push_fire   = bq.push_valid_i && !full && !squash_valid_reg && !mis_fire && !bq.flush_i;

    // Age of the resolving entry relative to the head; index arithmetic wraps
    // naturally because the depth is a power of two. Rebuilding the full pointer
    // from head keeps the wrap bit of the truncated tail consistent.
    assign res_dist   = bq.res_bqid_i - head_idx;
    assign branch_ptr = head_reg + {1'b0, res_dist};

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (bq.flush_i) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (commit_fire) begin
                head_next = head_reg + PTR_W'(1);
            end
            if (mis_fire) begin
                tail_next = branch_ptr + PTR_W'(1);
            end else if (push_fire) begin
                tail_next = tail_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
        logic [BQID_W-1:0] age;
        logic              hit_push, hit_commit, hit_res, kill;
        logic              valid_reg, resolved_reg, bp_taken_reg;
        pc_t               pc_reg, bp_pcnext_reg;
        id_t               id_reg;

        assign age        = BQID_W'(gi) - head_idx;
        assign kill       = mis_fire && (age > res_dist);
        assign hit_push   = push_fire && (tail_idx == BQID_W'(gi));
        assign hit_commit = commit_fire && (head_idx == BQID_W'(gi));
        assign hit_res    = res_ok && !bq.flush_i && (bq.res_bqid_i == BQID_W'(gi));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_reg     <= 1'b0;
                resolved_reg  <= 1'b0;
                bp_taken_reg  <= 1'b0;
                pc_reg        <= '0;
                bp_pcnext_reg <= '0;
                id_reg        <= '0;
            end else if (bq.flush_i) begin
                valid_reg    <= 1'b0;
                resolved_reg <= 1'b0;
            end else if (hit_push) begin
                valid_reg     <= 1'b1;
                resolved_reg  <= 1'b0;
                bp_taken_reg  <= bq.push_bp_taken_i;
                pc_reg        <= bq.push_pc_i;
                bp_pcnext_reg <= bq.push_bp_pcnext_i;
                id_reg        <= bq.push_id_i;
            end else begin
                if (kill || hit_commit) begin
                    valid_reg <= 1'b0;
                end
                if (hit_res) begin
                    resolved_reg <= 1'b1;
                end
            end
        end

        assign valid_vec[gi]     = valid_reg;
        assign resolved_vec[gi]  = resolved_reg;
        assign bp_taken_vec[gi]  = bp_taken_reg;
        assign pc_vec[gi]        = pc_reg;
        assign bp_pcnext_vec[gi] = bp_pcnext_reg;
        assign id_vec[gi]        = id_reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            squash_valid_reg <= 1'b0;
            squash_id_reg    <= '0;
            squash_pc_reg    <= '0;
        end else begin
            squash_valid_reg <= mis_fire;
            if (mis_fire) begin
                squash_id_reg <= id_vec[bq.res_bqid_i];
                squash_pc_reg <= redirect_pc;
            end
        end
    end

    // Commit may only retire a head that is resolved, or being resolved now.
    commit_head_resolved: assert property (@(posedge clk) disable iff (!rstn)
        (bq.commit_valid_i && !bq.flush_i) |->
            (!empty && (resolved_vec[head_idx] || (res_ok && (bq.res_bqid_i == head_idx)))));

endmodule

// File: tb/tb_branch_queue.sv
module tb_branch_queue;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int NR     = 8;
    localparam int ID_W   = 8;
    localparam int PC_W   = 64;
    localparam int BQID_W = 3;

    typedef struct packed {
        logic [BQID_W-1:0] bqid;
        logic [PC_W-1:0]   pc;
        logic [ID_W-1:0]   id;
        logic              bpt;
        logic [PC_W-1:0]   bpn;
        logic              resolved;
    } ent_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    branch_queue_if #(.NR_ENTRIES(NR), .ID_W(ID_W), .PC_W(PC_W), .BQID_W(BQID_W)) bq ();

    branch_queue #(.NR_ENTRIES(NR), .ID_W(ID_W), .PC_W(PC_W), .BQID_W(BQID_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bq   (bq)
    );

    // Reference model: program-ordered list of in-flight branches.
    ent_t            mq[$];
    int              next_bqid;
    logic            m_sq_valid;
    logic [ID_W-1:0] m_sq_id;
    logic [PC_W-1:0] m_sq_pc;

    int checks = 0;
    int errors = 0;

    task automatic set_idle();
        bq.push_valid_i     = 1'b0;
        bq.push_pc_i        = '0;
        bq.push_id_i        = '0;
        bq.push_bp_taken_i  = 1'b0;
        bq.push_bp_pcnext_i = '0;
        bq.res_valid_i      = 1'b0;
        bq.res_bqid_i       = '0;
        bq.res_taken_i      = 1'b0;
        bq.res_target_i     = '0;
        bq.commit_valid_i   = 1'b0;
        bq.flush_i          = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        next_bqid  = 0;
        m_sq_valid = 1'b0;
        m_sq_id    = '0;
        m_sq_pc    = '0;
    endtask

    // Drives one cycle of stimulus, advances the model, returns #1 after the edge.
    task automatic step(input logic pv, input logic [PC_W-1:0] ppc, input logic [ID_W-1:0] pid,
                        input logic pbt, input logic [PC_W-1:0] pbn,
                        input logic rv, input logic [BQID_W-1:0] rb, input logic rt,
                        input logic [PC_W-1:0] rtg, input logic cv, input logic fl);
        int   k;
        int   sz0;
        logic mis;
        ent_t e;
        bq.push_valid_i     = pv;
        bq.push_pc_i        = ppc;
        bq.push_id_i        = pid;
        bq.push_bp_taken_i  = pbt;
        bq.push_bp_pcnext_i = pbn;
        bq.res_valid_i      = rv;
        bq.res_bqid_i       = rb;
        bq.res_taken_i      = rt;
        bq.res_target_i     = rtg;
        bq.commit_valid_i   = cv;
        bq.flush_i          = fl;

        sz0 = mq.size();
        mis = 1'b0;
        k   = -1;
        if (fl) begin
            mq.delete();
            next_bqid  = 0;
            m_sq_valid = 1'b0;
        end else begin
            if (rv) begin
                for (int j = 0; j < mq.size(); j++)
                    if (mq[j].bqid == rb && !mq[j].resolved) k = j;
            end
            if (k >= 0) begin
                mq[k].resolved = 1'b1;
                mis = (rt != mq[k].bpt) || (rt && (rtg != mq[k].bpn));
                if (mis) begin
                    m_sq_id = mq[k].id;
                    m_sq_pc = rt ? rtg : (mq[k].pc + 64'd4);
                    while (mq.size() > k + 1) void'(mq.pop_back());
                    next_bqid = (int'(rb) + 1) % NR;
                end
            end
            if (cv && mq.size() > 0) void'(mq.pop_front());
            if (pv && sz0 < NR && !m_sq_valid && !mis) begin
                e.bqid     = BQID_W'(next_bqid);
                e.pc       = ppc;
                e.id       = pid;
                e.bpt      = pbt;
                e.bpn      = pbn;
                e.resolved = 1'b0;
                mq.push_back(e);
                next_bqid = (next_bqid + 1) % NR;
            end
            m_sq_valid = mis;
        end
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic do_push(input logic [PC_W-1:0] pc, input logic [ID_W-1:0] id,
                           input logic bpt, input logic [PC_W-1:0] bpn);
        step(1'b1, pc, id, bpt, bpn, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_resolve(input logic [BQID_W-1:0] b, input logic t, input logic [PC_W-1:0] tg);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, b, t, tg, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        set_idle();
        model_clear();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checks++;
        if ({bq.push_ready_o, bq.empty_o, bq.push_bqid_o, bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o}
            !== {1'b1, 1'b1, 3'd0, 1'b0, 8'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b empty=%b bqid=%0d sqv=%b sqid=%h sqpc=%h, expected 1 1 0 0 00 0",
                     bq.push_ready_o, bq.empty_o, bq.push_bqid_o, bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        do_push(64'h40, 8'h01, 1'b0, '0);
        do_push(64'h44, 8'h02, 1'b0, '0);
        do_push(64'h48, 8'h03, 1'b0, '0);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bq.empty_o, bq.push_bqid_o} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got empty=%b bqid=%0d, expected empty=1 bqid=0", bq.empty_o, bq.push_bqid_o);
        end
        model_clear();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        do_flush();
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (bq.push_bqid_o !== BQID_W'(i)) begin
                errors++;
                $display("FAIL fill_bqid: push %0d got bqid %0d, expected %0d", i, bq.push_bqid_o, i);
            end
            do_push(64'h1000 + 64'(i * 4), ID_W'(i), 1'b0, '0);
        end
        checks++;
        if ({bq.push_ready_o, bq.empty_o} !== 2'b00) begin
            errors++;
            $display("FAIL fill_full: got rdy=%b empty=%b, expected 0 0", bq.push_ready_o, bq.empty_o);
        end
        do_push(64'h2000, 8'h99, 1'b0, '0);
        checks++;
        if ({bq.push_ready_o, bq.push_bqid_o} !== {1'b0, 3'd0} || mq.size() != NR) begin
            errors++;
            $display("FAIL fill_ninth_ignored: got rdy=%b bqid=%0d, expected rdy=0 bqid=0", bq.push_ready_o, bq.push_bqid_o);
        end
        for (int i = 0; i < NR; i++) do_resolve(BQID_W'(i), 1'b0, '0);
        for (int i = 0; i < NR; i++) begin
            step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bq.squash_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL fill_drain_squash: commit %0d got squash %b, expected 0", i, bq.squash_valid_o);
            end
        end
        checks++;
        if (bq.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained_empty: got %b, expected 1", bq.empty_o);
        end
    endtask

    task automatic test_mispredict_taken();
        do_flush();
        do_push(64'h1000, 8'h21, 1'b0, '0);
        do_resolve(3'd0, 1'b1, 64'h2000);
        checks++;
        if ({bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o} !== {1'b1, 8'h21, 64'h2000}) begin
            errors++;
            $display("FAIL mis_taken_squash: got v=%b id=%h pc=%h, expected v=1 id=21 pc=2000",
                     bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o);
        end
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (bq.squash_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_taken_one_cycle: got squash %b, expected 0", bq.squash_valid_o);
        end
    endtask

    task automatic test_mispredict_not_taken();
        do_flush();
        do_push(64'h1000, 8'h31, 1'b1, 64'h1800);
        do_push(64'h1800, 8'h32, 1'b0, '0);
        do_push(64'h1804, 8'h33, 1'b0, '0);
        do_resolve(3'd0, 1'b0, '0);
        checks++;
        if ({bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o} !== {1'b1, 8'h31, 64'h1004}) begin
            errors++;
            $display("FAIL mis_nt_squash: got v=%b id=%h pc=%h, expected v=1 id=31 pc=1004",
                     bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o);
        end
        checks++;
        if (bq.push_bqid_o !== 3'd1) begin
            errors++;
            $display("FAIL mis_nt_tail: got bqid %0d, expected 1", bq.push_bqid_o);
        end
        do_resolve(3'd1, 1'b1, 64'h9999);
        checks++;
        if (bq.squash_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_nt_young_gone: got squash %b, expected 0", bq.squash_valid_o);
        end
    endtask

    task automatic test_trunc_push();
        do_flush();
        for (int i = 0; i < 5; i++) do_push(64'h3000 + 64'(i * 4), ID_W'(8'h10 + i), 1'b0, '0);
        step(1'b1, 64'h4000, 8'h77, 1'b0, '0, 1'b1, 3'd1, 1'b1, 64'h3100, 1'b0, 1'b0);
        checks++;
        if ({bq.squash_valid_o, bq.squash_id_o, bq.push_bqid_o} !== {1'b1, 8'h11, 3'd2}) begin
            errors++;
            $display("FAIL trunc_push_dropped: got v=%b id=%h bqid=%0d, expected v=1 id=11 bqid=2",
                     bq.squash_valid_o, bq.squash_id_o, bq.push_bqid_o);
        end
        do_resolve(3'd3, 1'b1, 64'h5000);
        checks++;
        if ({bq.squash_valid_o, bq.push_bqid_o} !== {1'b0, 3'd2}) begin
            errors++;
            $display("FAIL trunc_stale_resolve: got v=%b bqid=%0d, expected v=0 bqid=2",
                     bq.squash_valid_o, bq.push_bqid_o);
        end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bq.push_bqid_o !== BQID_W'(i % NR)) begin
                errors++;
                $display("FAIL wrap_bqid: iter %0d got %0d, expected %0d", i, bq.push_bqid_o, i % NR);
            end
            do_push(64'h8000 + 64'(i * 16), ID_W'(i), 1'b1, 64'h100);
            do_resolve(BQID_W'(i % NR), 1'b1, 64'h100);
            step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bq.squash_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL wrap_no_squash: iter %0d got squash %b, expected 0", i, bq.squash_valid_o);
            end
        end
        checks++;
        if (bq.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty: got %b, expected 1", bq.empty_o);
        end
    endtask

    task automatic test_flush_mis();
        do_flush();
        do_push(64'h6000, 8'h55, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd0, 1'b1, 64'h7000, 1'b0, 1'b1);
        checks++;
        if ({bq.squash_valid_o, bq.empty_o, bq.push_bqid_o} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL flush_beats_squash: got v=%b empty=%b bqid=%0d, expected 0 1 0",
                     bq.squash_valid_o, bq.empty_o, bq.push_bqid_o);
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        do_push(64'hA000, 8'h41, 1'b0, '0);
        do_push(64'hA010, 8'h42, 1'b0, '0);
        do_resolve(3'd1, 1'b1, 64'h5000);
        checks++;
        if ({bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o} !== {1'b1, 8'h42, 64'h5000}) begin
            errors++;
            $display("FAIL b2b_first: got v=%b id=%h pc=%h, expected v=1 id=42 pc=5000",
                     bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o);
        end
        do_resolve(3'd0, 1'b1, 64'h6000);
        checks++;
        if ({bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o, bq.push_bqid_o} !== {1'b1, 8'h41, 64'h6000, 3'd1}) begin
            errors++;
            $display("FAIL b2b_older: got v=%b id=%h pc=%h bqid=%0d, expected v=1 id=41 pc=6000 bqid=1",
                     bq.squash_valid_o, bq.squash_id_o, bq.squash_pc_o, bq.push_bqid_o);
        end
        // Head mispredicts while being committed in the same cycle.
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        do_push(64'hB000, 8'h43, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd1, 1'b1, 64'hC000, 1'b1, 1'b0);
        checks++;
        if ({bq.squash_valid_o, bq.squash_id_o, bq.empty_o, bq.push_bqid_o} !== {1'b1, 8'h43, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL commit_mis_head: got v=%b id=%h empty=%b bqid=%0d, expected v=1 id=43 empty=1 bqid=2",
                     bq.squash_valid_o, bq.squash_id_o, bq.empty_o, bq.push_bqid_o);
        end
    endtask

    task automatic test_random();
        logic              pv, pbt, rv, rt, cv, fl, er, ee;
        logic [PC_W-1:0]   ppc, pbn, rtg;
        logic [ID_W-1:0]   pid;
        logic [BQID_W-1:0] rb;
        int                j;
        do_flush();
        for (int c = 0; c < 600; c++) begin
            pv  = ($urandom_range(0, 3) != 0);
            ppc = {$urandom, $urandom};
            pid = ID_W'($urandom);
            pbt = 1'($urandom_range(0, 1));
            pbn = ($urandom_range(0, 1) != 0) ? 64'h100 : 64'h200;
            rv  = 1'b0;
            rb  = '0;
            rt  = 1'b0;
            rtg = '0;
            if ($urandom_range(0, 1) != 0) begin
                rv = 1'b1;
                if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
                    j  = int'($urandom_range(0, mq.size() - 1));
                    rb = mq[j].bqid;
                    if ($urandom_range(0, 3) != 0) begin
                        rt  = mq[j].bpt;
                        rtg = mq[j].bpn;
                    end else begin
                        rt  = 1'($urandom_range(0, 1));
                        rtg = ($urandom_range(0, 1) != 0) ? 64'h100 : 64'h200;
                    end
                end else begin
                    rb  = BQID_W'($urandom);
                    rt  = 1'($urandom_range(0, 1));
                    rtg = ($urandom_range(0, 1) != 0) ? 64'h100 : 64'h200;
                end
            end
            cv = (mq.size() > 0) && mq[0].resolved && ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 99) == 0);
            step(pv, ppc, pid, pbt, pbn, rv, rb, rt, rtg, cv, fl);

            checks++;
            if (bq.squash_valid_o !== m_sq_valid) begin
                errors++;
                $display("FAIL rnd_squash_valid: cycle %0d got %b, expected %b", c, bq.squash_valid_o, m_sq_valid);
            end
            if (m_sq_valid) begin
                checks++;
                if ({bq.squash_id_o, bq.squash_pc_o} !== {m_sq_id, m_sq_pc}) begin
                    errors++;
                    $display("FAIL rnd_squash_data: cycle %0d got id=%h pc=%h, expected id=%h pc=%h",
                             c, bq.squash_id_o, bq.squash_pc_o, m_sq_id, m_sq_pc);
                end
            end
            er = (mq.size() < NR);
            ee = (mq.size() == 0);
            checks++;
            if ({bq.push_ready_o, bq.empty_o, bq.push_bqid_o} !== {er, ee, BQID_W'(next_bqid)}) begin
                errors++;
                $display("FAIL rnd_pointers: cycle %0d got rdy=%b empty=%b bqid=%0d, expected rdy=%b empty=%b bqid=%0d",
                         c, bq.push_ready_o, bq.empty_o, bq.push_bqid_o, er, ee, next_bqid);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_async_reset();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_trunc_push();
        test_wrap();
        test_flush_mis();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
